// File: rtl/super_register_8bit.sv
// 8-bit multi-function register: load, serial shift, rotate, hold and up/down
// count. A registered flag holds the bit shifted or rotated out, or the counter carry/borrow.
module super_register_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [2:0] operation,
  input  logic       in_shift_right,
  input  logic       in_shift_left,
  output logic [7:0] out_data,
  output logic       flag
);

  typedef enum logic [2:0] {
    OP_LOAD         = 3'd0,
    OP_SHIFT_RIGHT  = 3'd1,
    OP_SHIFT_LEFT   = 3'd2,
    OP_ROTATE_RIGHT = 3'd3,
    OP_ROTATE_LEFT  = 3'd4,
    OP_STORE        = 3'd5,
    OP_COUNT_UP     = 3'd6,
    OP_COUNT_DOWN   = 3'd7
  } op_e;

  logic [7:0] data_r;
  logic       flag_r;
  logic [7:0] data_next_s;
  logic       flag_next_s;
  op_e        op_s;

  assign op_s = op_e'(operation);

  // Next register value and status flag for the sampled opcode.
  always_comb begin
    data_next_s = data_r;
    flag_next_s = flag_r;
    case (op_s)
      OP_LOAD: begin
        data_next_s = in_data;
        flag_next_s = 1'b0;
      end
      OP_SHIFT_RIGHT: begin
        data_next_s = {in_shift_right, data_r[7:1]};
        flag_next_s = data_r[0];
      end
      OP_SHIFT_LEFT: begin
        data_next_s = {data_r[6:0], in_shift_left};
        flag_next_s = data_r[7];
      end
      OP_ROTATE_RIGHT: begin
        data_next_s = {data_r[0], data_r[7:1]};
        flag_next_s = data_r[0];
      end
      OP_ROTATE_LEFT: begin
        data_next_s = {data_r[6:0], data_r[7]};
        flag_next_s = data_r[7];
      end
      OP_STORE: begin
        data_next_s = data_r;
        flag_next_s = flag_r;
      end
      OP_COUNT_UP: begin
        // 9-bit sum: the carry out becomes the flag
        {flag_next_s, data_next_s} = {1'b0, data_r} + 9'd1;
      end
      OP_COUNT_DOWN: begin
        data_next_s = data_r - 8'd1;
        flag_next_s = (data_r == 8'h00) ? 1'b1 : 1'b0;
      end
      default: begin
        data_next_s = data_r;
        flag_next_s = flag_r;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= 8'h00;
      flag_r <= 1'b0;
    end else begin
      data_r <= data_next_s;
      flag_r <= flag_next_s;
    end
  end

  assign out_data = data_r;
  assign flag     = flag_r;

endmodule

// File: tb/tb_super_register_8bit.sv
// Table-driven self-checking bench for super_register_8bit, plus a hand-written
// asynchronous-reset-during-count sequence.
module tb_super_register_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [2:0] operation;
  logic       in_shift_right;
  logic       in_shift_left;
  logic [7:0] out_data;
  logic       flag;

  int checks_total;
  int checks_passed;

  localparam logic [2:0] LD  = 3'd0;
  localparam logic [2:0] SHR = 3'd1;
  localparam logic [2:0] SHL = 3'd2;
  localparam logic [2:0] ROR = 3'd3;
  localparam logic [2:0] ROL = 3'd4;
  localparam logic [2:0] STO = 3'd5;
  localparam logic [2:0] UP  = 3'd6;
  localparam logic [2:0] DN  = 3'd7;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] din;
    logic       sr;
    logic       sl;
    logic [7:0] exp_data;
    logic       exp_flag;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  super_register_8bit dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .operation      (operation),
    .in_shift_right (in_shift_right),
    .in_shift_left  (in_shift_left),
    .out_data       (out_data),
    .flag           (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act_d, input logic act_f,
                       input logic [7:0] exp_d, input logic exp_f);
    checks_total++;
    if (act_d === exp_d && act_f === exp_f) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got data=%02h flag=%0b, expected data=%02h flag=%0b",
               name, act_d, act_f, exp_d, exp_f);
    end
  endtask

  task automatic add(input string name, input logic [2:0] op, input logic [7:0] din,
                     input logic sr, input logic sl, input logic [7:0] ed, input logic ef);
    vecs[nvec].name     = name;
    vecs[nvec].op       = op;
    vecs[nvec].din      = din;
    vecs[nvec].sr       = sr;
    vecs[nvec].sl       = sl;
    vecs[nvec].exp_data = ed;
    vecs[nvec].exp_flag = ef;
    nvec++;
  endtask

  initial begin
    checks_total   = 0;
    checks_passed  = 0;
    nvec           = 0;
    rst            = 1'b0;
    in_data        = 8'h00;
    operation      = STO;
    in_shift_right = 1'b0;
    in_shift_left  = 1'b0;

    // Reset and hold: in_data must be ignored by store
    for (int i = 0; i < 3; i++) add("store_after_reset", STO, 8'hA4, 1'b1, 1'b1, 8'h00, 1'b0);
    // Load and count (in_data noise must not matter)
    add("load_a4", LD, 8'hA4, 1'b0, 1'b0, 8'hA4, 1'b0);
    for (int i = 1; i <= 10; i++) add("count_up", UP, 8'h5A, 1'b1, 1'b1, 8'(8'hA4 + i), 1'b0);
    for (int i = 1; i <= 5; i++)  add("count_down", DN, 8'h11, 1'b1, 1'b1, 8'(8'hAE - i), 1'b0);
    // Shift right
    add("load_73", LD, 8'h73, 1'b0, 1'b0, 8'h73, 1'b0);
    add("shr_0", SHR, 8'h00, 1'b0, 1'b1, 8'h39, 1'b1);
    add("shr_1a", SHR, 8'h00, 1'b1, 1'b0, 8'h9C, 1'b1);
    add("shr_1b", SHR, 8'h00, 1'b1, 1'b0, 8'hCE, 1'b0);
    // Shift / rotate left, rotate right, store keeps flag
    add("load_73b", LD, 8'h73, 1'b0, 1'b0, 8'h73, 1'b0);
    add("shl_0a", SHL, 8'h00, 1'b1, 1'b0, 8'hE6, 1'b0);
    add("shl_0b", SHL, 8'h00, 1'b1, 1'b0, 8'hCC, 1'b1);
    add("rol_a", ROL, 8'h00, 1'b0, 1'b0, 8'h99, 1'b1);
    add("rol_b", ROL, 8'h00, 1'b0, 1'b0, 8'h33, 1'b1);
    add("ror", ROR, 8'h00, 1'b0, 1'b0, 8'h99, 1'b1);
    add("store_keep_flag", STO, 8'h00, 1'b0, 1'b0, 8'h99, 1'b1);
    add("shl_1", SHL, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1);
    add("ror_ignores_sr", ROR, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1);
    add("rol_ignores_sl", ROL, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1);
    // Wrap boundaries
    add("load_ff", LD, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0);
    add("up_wrap", UP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    add("store_wrap_flag", STO, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    add("down_wrap", DN, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
    add("down_plain", DN, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0);
    add("up_plain", UP, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
    add("load_clears_flag_pre", UP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    add("load_clears_flag", LD, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0);

    // Reset pulse and immediate reset state
    #2 rst = 1'b1;
    #1 check("reset_state", out_data, flag, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      operation      = vecs[i].op;
      in_data        = vecs[i].din;
      in_shift_right = vecs[i].sr;
      in_shift_left  = vecs[i].sl;
      @(posedge clk);
      #1 check(vecs[i].name, out_data, flag, vecs[i].exp_data, vecs[i].exp_flag);
      @(negedge clk);
    end

    // Async reset in the middle of a count sequence
    operation = LD;
    in_data   = 8'h40;
    @(posedge clk);
    @(negedge clk);
    operation = UP;
    @(posedge clk);
    @(negedge clk);
    operation = UP;
    @(posedge clk);
    #1 check("count_to_42", out_data, flag, 8'h42, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_reset_immediate", out_data, flag, 8'h00, 1'b0);
    @(posedge clk);
    #1 check("edge_during_reset", out_data, flag, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("count_after_reset", out_data, flag, 8'h01, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
